aq_dcache_tag_array_cfg: RTL and testbench
==========================================

// Module: aq_dcache_tag_array_cfg
// PURPOSE
//  Parametrised L1 D-cache tag array: WAYS ways split across BANKS SRAM banks, each bank with its own gated clock.
//  Each way entry is {valid, tag}.
//  Adds a self-clearing init/invalidate-all sweep FSM, a ready handshake, and a registered read output with a valid strobe.
//  Sits between the LSU tag pipeline and the per-bank SPSRAM macros. Memory is held in behavioural reg arrays.
// PARAMETERS
//  WAYS     4   number of ways; must be a multiple of BANKS
//  BANKS    2   SRAM banks; each bank holds WAYS/BANKS ways
//  TAG_W    28  tag field width per way
//  INDEX_W  6   set index width; depth = 2**INDEX_W
//  ENTRY_W  TAG_W+1 (derived)  per-way entry, bit [TAG_W] = valid
// PORTS
//  forever_cpuclk      in   1               core clock
//  cpurst              in   1               reset, asynchronous, active-high
//  cp0_lsu_icg_en      in   1               ICG module enable
//  pad_yy_icg_scan_en  in   1               ICG scan enable
//  tag_req             in   1               access request
//  tag_gwen            in   1               1 = read, 0 = write
//  tag_idx             in   INDEX_W         set index
//  tag_way             in   WAYS            way select; banks with any selected way are accessed
//  tag_wen             in   WAYS*ENTRY_W    bit write enable, active-low
//  tag_din             in   WAYS*ENTRY_W    write data
//  inv_all_req         in   1               start an invalidate-all sweep
//  tag_rdy             out  1               array accepts tag_req
//  tag_dout            out  WAYS*ENTRY_W    registered read data
//  tag_dout_vld        out  1               1-cycle strobe: tag_dout updated
//  tag_par_err         out  WAYS            per-way parity error, qualified by tag_dout_vld
//  inv_all_done        out  1               1-cycle strobe: sweep finished
// BEHAVIOUR
//  - Reset values: state=INIT, cnt=0, tag_rdy=0, tag_dout=0, tag_dout_vld=0, tag_par_err=0, inv_all_done=0.
//    Reset asserted mid-sweep or mid-read restarts INIT at cnt=0.
//  - FSM states INIT/IDLE:
//    - INIT: each cycle writes all ways at index cnt with 0 (valid=0, tag=0, parity=0).
//      At cnt==2**INDEX_W-1 that final write completes, state moves to IDLE, and inv_all_done pulses for the first IDLE cycle.
//      The sweep always lasts exactly 2**INDEX_W cycles.
//    - IDLE: tag_rdy=1. inv_all_req moves to INIT with cnt=0 on the next cycle.
//      inv_all_req in INIT is ignored; the sweep does not restart.
//    - tag_req together with inv_all_req in IDLE: the access is performed, then the sweep starts.
//  - tag_req while tag_rdy=0 is dropped. The requester holds tag_req until it sees tag_rdy.
//  - Read (tag_req & tag_rdy & tag_gwen):
//    - Registered one-cycle latency: tag_dout and tag_dout_vld update at the edge after the acceptance edge.
//    - Ways in banks not selected return 0.
//    - tag_dout holds its value until the next read. Writes and the sweep never alter it.
//  - Write (tag_req & tag_rdy & ~tag_gwen): in each selected bank, bit i is written where tag_wen[i]==0. Unselected banks are untouched.
//  - Read of an index written on the previous accepted cycle returns the new data (no stale-data hazard).
//  - Bank b clock enable = (tag_req & tag_rdy & bank b selected) | (state==INIT), through one gated_clk_cell per bank.
//  - tag_way all-zero with tag_req: no bank accessed. For a read, tag_dout_vld still pulses with all-zero data.
// CONFIGURATION
//  - Macro AQ_DCACHE_TAG_PARITY_EN defined:
//    - Each way stores an extra even-parity bit over its tag field.
//    - The parity bit is written whenever that way's tag bits are write-enabled. Tag writes are all-or-nothing per way; a mixed mask is illegal and flagged by an assertion.
//    - Valid-only writes leave parity unchanged.
//    - On read, tag_par_err[w] = valid[w] & (^tag[w] != par[w]), registered with tag_dout. Invalid ways never flag.
//  - Macro not defined: no parity storage; tag_par_err is tied to 0.
// TESTING
//  1. Release reset, WAYS=4, INDEX_W=6 -> tag_rdy=0 for 64 cycles, inv_all_done pulses once, then tag_rdy=1.
//     A read of every index returns all 0.
//  2. Write idx 5, way 2, {valid=1, tag=28'hABCDE12}, full mask -> the next-cycle read of idx 5, tag_way=4'hF returns way2=29'h1ABCDE12, others 0.
//     tag_dout_vld is high for exactly 1 cycle.
//  3. Write only the valid bit (wen=0 on bit 28 only) to clear idx 5 way 2 -> a read returns tag 28'hABCDE12 with valid=0.
//  4. Read with tag_way=4'b0001 -> bank1 clock does not toggle; ways 2-3 of tag_dout read 0.
//  5. inv_all_req while idx 5 is valid -> tag_rdy drops the next cycle. Requests during the sweep are ignored.
//     After inv_all_done, idx 5 reads 0. A second inv_all_req mid-sweep does not extend the sweep.
//  6. AQ_DCACHE_TAG_PARITY_EN defined, backdoor-flip tag bit 0 of a valid way -> the read returns tag_par_err for that way only.
//     With the macro not defined, tag_par_err stays 0.

Source files
------------

// File: rtl/aq_dcache_tag_array_cfg.sv
// rtl/aq_dcache_tag_array_cfg.sv - banked L1 D-cache tag array with init sweep and registered read
//
// Purpose:
//   WAYS-way tag array, split evenly over BANKS behavioural SRAM banks. Each bank
//   is clocked through its own gated_clk_cell. Each way entry is {valid, tag}.
//   After reset, and on inv_all_req, an INIT sweep clears every index, one index
//   per cycle. tag_rdy is low for the whole sweep. Reads return registered data
//   one cycle after acceptance, together with a one-cycle tag_dout_vld strobe.
//
// Ports:
//   forever_cpuclk      core clock
//   cpurst              asynchronous active-high reset
//   cp0_lsu_icg_en      forces all bank clocks on
//   pad_yy_icg_scan_en  forces all bank clocks on during scan
//   tag_req/tag_gwen    access request; gwen=1 read, gwen=0 write
//   tag_idx/tag_way     set index and way select (selected ways choose the banks)
//   tag_wen/tag_din     active-low bit write enable and write data
//   inv_all_req         start an invalidate-all sweep
//   tag_rdy             array accepts tag_req
//   tag_dout/_vld       registered read data and update strobe
//   tag_par_err         per-way parity error, qualified by tag_dout_vld
//   inv_all_done        one-cycle strobe on the first IDLE cycle after a sweep
//
// Optional feature: define AQ_DCACHE_TAG_PARITY_EN to store a per-way even-parity
//   bit over the tag field and to report tag_par_err on reads.

module gated_clk_cell (
  input  logic clk_in,
  input  logic module_en,
  input  logic local_en,
  input  logic pad_yy_icg_scan_en,
  output logic clk_out
);
  logic en_d;
  logic en_q;

  always_comb begin
    en_d = module_en | local_en | pad_yy_icg_scan_en;
  end

  // Enable is captured while the clock is low, so clk_out cannot glitch.
  always_ff @(negedge clk_in) begin
    en_q <= en_d;
  end

  assign clk_out = clk_in & en_q;
endmodule

module aq_dcache_tag_array_cfg #(
  parameter int WAYS    = 4,
  parameter int BANKS   = 2,
  parameter int TAG_W   = 28,
  parameter int INDEX_W = 6
) (
  input  logic                        forever_cpuclk,
  input  logic                        cpurst,
  input  logic                        cp0_lsu_icg_en,
  input  logic                        pad_yy_icg_scan_en,
  input  logic                        tag_req,
  input  logic                        tag_gwen,
  input  logic [INDEX_W-1:0]          tag_idx,
  input  logic [WAYS-1:0]             tag_way,
  input  logic [WAYS*(TAG_W+1)-1:0]   tag_wen,
  input  logic [WAYS*(TAG_W+1)-1:0]   tag_din,
  input  logic                        inv_all_req,
  output logic                        tag_rdy,
  output logic [WAYS*(TAG_W+1)-1:0]   tag_dout,
  output logic                        tag_dout_vld,
  output logic [WAYS-1:0]             tag_par_err,
  output logic                        inv_all_done
);
  localparam int ENTRY_W = TAG_W + 1;
  localparam int DEPTH   = 1 << INDEX_W;
  localparam int WPB     = WAYS / BANKS;
  localparam int BANK_W  = WPB * ENTRY_W;
  localparam int DATA_W  = WAYS * ENTRY_W;
  localparam logic [INDEX_W-1:0] CNT_LAST = '1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [INDEX_W-1:0]   cnt_q, cnt_d;
  logic                 inv_all_done_q, inv_all_done_d;
  logic                 rd_pend_q, rd_pend_d;
  logic [INDEX_W-1:0]   rd_idx_q, rd_idx_d;
  logic [BANKS-1:0]     rd_bank_q, rd_bank_d;
  logic [DATA_W-1:0]    tag_dout_q, tag_dout_d;
  logic                 tag_dout_vld_q, tag_dout_vld_d;

  logic                 acc;
  logic                 acc_rd;
  logic                 acc_wr;
  logic                 sweep;
  logic [BANKS-1:0]     bank_sel;
  logic [BANKS-1:0]     bank_en;
  logic [BANKS-1:0]     bank_clk;
  logic [DATA_W-1:0]    rd_data;
  logic [INDEX_W-1:0]   wr_addr;

  assign tag_rdy = (state_q == ST_IDLE);
  assign sweep   = (state_q == ST_INIT);
  assign acc     = tag_req & tag_rdy;
  assign acc_rd  = acc & tag_gwen;
  assign acc_wr  = acc & ~tag_gwen;
  assign wr_addr = sweep ? cnt_q : tag_idx;

  // A bank takes part in an access when any of its ways is selected.
  always_comb begin
    bank_sel = '0;
    for (int b = 0; b < BANKS; b++) begin
      bank_sel[b] = |tag_way[b*WPB +: WPB];
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    inv_all_done_d = 1'b0;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d        = ST_IDLE;
          cnt_d          = '0;
          inv_all_done_d = 1'b1;
        end
      end
      ST_IDLE: begin
        // Any access accepted this cycle completes before the sweep begins.
        if (inv_all_req) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Read address is latched at acceptance; the arrays are sampled on the next
  // edge, before any write issued on that edge lands.
  always_comb begin
    rd_pend_d      = acc_rd;
    rd_idx_d       = acc_rd ? tag_idx : rd_idx_q;
    rd_bank_d      = acc_rd ? bank_sel : rd_bank_q;
    tag_dout_d     = rd_pend_q ? rd_data : tag_dout_q;
    tag_dout_vld_d = rd_pend_q;
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state_q        <= ST_INIT;
      cnt_q          <= '0;
      inv_all_done_q <= 1'b0;
      rd_pend_q      <= 1'b0;
      rd_idx_q       <= '0;
      rd_bank_q      <= '0;
      tag_dout_q     <= '0;
      tag_dout_vld_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      inv_all_done_q <= inv_all_done_d;
      rd_pend_q      <= rd_pend_d;
      rd_idx_q       <= rd_idx_d;
      rd_bank_q      <= rd_bank_d;
      tag_dout_q     <= tag_dout_d;
      tag_dout_vld_q <= tag_dout_vld_d;
    end
  end

  assign tag_dout     = tag_dout_q;
  assign tag_dout_vld = tag_dout_vld_q;
  assign inv_all_done = inv_all_done_q;

`ifdef AQ_DCACHE_TAG_PARITY_EN
  logic [WAYS-1:0] rd_par;
  logic [WAYS-1:0] tag_par_err_q, tag_par_err_d;
`endif

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [BANK_W-1:0] tag_mem [DEPTH];
    logic [BANK_W-1:0] wr_data;
    logic              wr_en;

    assign bank_en[b] = (acc & bank_sel[b]) | sweep;

    gated_clk_cell u_icg (
      .clk_in             (forever_cpuclk),
      .module_en          (cp0_lsu_icg_en),
      .local_en           (bank_en[b]),
      .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
      .clk_out            (bank_clk[b])
    );

    // The bank clock may be forced on, so the write itself is still qualified.
    always_comb begin
      wr_en   = sweep | (acc_wr & bank_sel[b]);
      wr_data = '0;
      if (!sweep) begin
        wr_data = (tag_mem[tag_idx] & tag_wen[b*BANK_W +: BANK_W])
                | (tag_din[b*BANK_W +: BANK_W] & ~tag_wen[b*BANK_W +: BANK_W]);
      end
    end

    always_ff @(posedge bank_clk[b]) begin
      if (wr_en) begin
        tag_mem[wr_addr] <= wr_data;
      end
    end

    assign rd_data[b*BANK_W +: BANK_W] = rd_bank_q[b] ? tag_mem[rd_idx_q] : '0;

`ifdef AQ_DCACHE_TAG_PARITY_EN
    logic [WPB-1:0] par_mem [DEPTH];
    logic [WPB-1:0] par_wr_data;
    logic [WPB-1:0] par_wr_mask;

    // Parity follows the tag field only; valid-only writes keep the old bit.
    always_comb begin
      par_wr_data = '0;
      par_wr_mask = '0;
      for (int w = 0; w < WPB; w++) begin
        par_wr_mask[w] = sweep | ~(|tag_wen[b*BANK_W + w*ENTRY_W +: TAG_W]);
        par_wr_data[w] = sweep ? 1'b0 : ^tag_din[b*BANK_W + w*ENTRY_W +: TAG_W];
      end
    end

    always_ff @(posedge bank_clk[b]) begin
      if (wr_en) begin
        par_mem[wr_addr] <= (par_mem[wr_addr] & ~par_wr_mask) | (par_wr_data & par_wr_mask);
      end
    end

    assign rd_par[b*WPB +: WPB] = rd_bank_q[b] ? par_mem[rd_idx_q] : '0;
`endif
  end

`ifdef AQ_DCACHE_TAG_PARITY_EN
  // Ways in unselected banks read as invalid and therefore never flag.
  always_comb begin
    tag_par_err_d = tag_par_err_q;
    if (rd_pend_q) begin
      for (int w = 0; w < WAYS; w++) begin
        tag_par_err_d[w] = rd_data[w*ENTRY_W + TAG_W]
                         & ((^rd_data[w*ENTRY_W +: TAG_W]) != rd_par[w]);
      end
    end
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      tag_par_err_q <= '0;
    end else begin
      tag_par_err_q <= tag_par_err_d;
    end
  end

  assign tag_par_err = tag_par_err_q;

  // Tag bits of a way must be written all together or not at all, or the
  // stored parity would not describe the stored tag.
  always @(posedge forever_cpuclk) begin
    if (!cpurst && acc_wr) begin
      for (int w = 0; w < WAYS; w++) begin
        if (bank_sel[w/WPB]) begin
          assert ((&tag_wen[w*ENTRY_W +: TAG_W]) || !(|tag_wen[w*ENTRY_W +: TAG_W]))
            else $error("mixed tag write mask on way %0d", w);
        end
      end
    end
  end
`else
  assign tag_par_err = '0;
`endif

endmodule

// File: tb/tb_aq_dcache_tag_array_cfg.sv
// tb/tb_aq_dcache_tag_array_cfg.sv - self-checking bench for aq_dcache_tag_array_cfg
module tb_aq_dcache_tag_array_cfg;
  localparam int WAYS = 4, BANKS = 2, TAG_W = 28, INDEX_W = 6;
  localparam int EW = TAG_W + 1, DW = WAYS * EW, DEPTH = 64, WPB = WAYS / BANKS;

  logic clk = 1'b0, rst = 1'b1, icg_en = 1'b0, scan_en = 1'b0;
  logic tag_req = 1'b0, tag_gwen = 1'b0, inv_all_req = 1'b0;
  logic [INDEX_W-1:0] tag_idx = '0;
  logic [WAYS-1:0] tag_way = '0;
  logic [DW-1:0] tag_wen = '1, tag_din = '0;
  logic tag_rdy, tag_dout_vld, inv_all_done;
  logic [DW-1:0] tag_dout;
  logic [WAYS-1:0] tag_par_err;

  int total = 0, bad = 0;
  logic [EW-1:0] ref_mem [WAYS][DEPTH];
  logic [DW-1:0] ref_dout = '0;

  aq_dcache_tag_array_cfg #(.WAYS(WAYS), .BANKS(BANKS), .TAG_W(TAG_W), .INDEX_W(INDEX_W)) dut (
    .forever_cpuclk(clk), .cpurst(rst), .cp0_lsu_icg_en(icg_en), .pad_yy_icg_scan_en(scan_en),
    .tag_req(tag_req), .tag_gwen(tag_gwen), .tag_idx(tag_idx), .tag_way(tag_way),
    .tag_wen(tag_wen), .tag_din(tag_din), .inv_all_req(inv_all_req), .tag_rdy(tag_rdy),
    .tag_dout(tag_dout), .tag_dout_vld(tag_dout_vld), .tag_par_err(tag_par_err),
    .inv_all_done(inv_all_done)
  );

  always #5 clk = ~clk;

  wire b0clk = dut.bank_clk[0];
  wire b1clk = dut.bank_clk[1];
  int b_edges [BANKS] = '{0, 0};
  always @(posedge b0clk) b_edges[0]++;
  always @(posedge b1clk) b_edges[1]++;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ent(input int w, input logic [EW-1:0] v);
    logic [DW-1:0] r = '0;
    r[w*EW +: EW] = v;
    return r;
  endfunction

  // A bank is touched when any of the ways it owns is selected.
  function automatic logic bank_hit(input logic [WAYS-1:0] way, input int bank);
    for (int j = 0; j < WAYS; j++) if (way[j] && (j / WPB) == bank) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [INDEX_W-1:0] idx, input logic [WAYS-1:0] way);
    logic [DW-1:0] r = '0;
    for (int w = 0; w < WAYS; w++) if (bank_hit(way, w / WPB)) r[w*EW +: EW] = ref_mem[w][idx];
    return r;
  endfunction

  task automatic model_write(input logic [INDEX_W-1:0] idx, input logic [WAYS-1:0] way,
                             input logic [DW-1:0] wen, input logic [DW-1:0] din);
    for (int w = 0; w < WAYS; w++)
      if (bank_hit(way, w / WPB))
        for (int k = 0; k < EW; k++)
          if (!wen[w*EW + k]) ref_mem[w][idx][k] = din[w*EW + k];
  endtask

  task automatic model_clear();
    for (int w = 0; w < WAYS; w++) for (int i = 0; i < DEPTH; i++) ref_mem[w][i] = '0;
  endtask

  // Present one request for a single accepting edge, then withdraw it.
  task automatic issue(input logic rd, input logic [INDEX_W-1:0] idx, input logic [WAYS-1:0] way,
                       input logic [DW-1:0] wen, input logic [DW-1:0] din, input logic inv);
    tag_req = 1'b1; tag_gwen = rd; tag_idx = idx; tag_way = way;
    tag_wen = wen; tag_din = din; inv_all_req = inv;
    @(posedge clk); #1;
    tag_req = 1'b0; inv_all_req = 1'b0;
  endtask

  task automatic do_write(input logic [INDEX_W-1:0] idx, input logic [WAYS-1:0] way,
                          input logic [DW-1:0] wen, input logic [DW-1:0] din);
    issue(1'b0, idx, way, wen, din, 1'b0);
    model_write(idx, way, wen, din);
  endtask

  task automatic do_read(input string name, input logic [INDEX_W-1:0] idx, input logic [WAYS-1:0] way);
    ref_dout = model_read(idx, way);
    issue(1'b1, idx, way, '1, '0, 1'b0);
    @(posedge clk); #1;
    check({name, "_vld"}, tag_dout_vld, 1);
    check({name, "_dout"}, tag_dout, ref_dout);
  endtask

  // Counts sweep cycles from the edge after the sweep was entered. Optionally
  // re-requests a sweep at cycle inv_at and holds a write request in [wr_from, wr_to).
  task automatic wait_sweep(input string name, input int start, input int inv_at,
                            input int wr_from, input int wr_to);
    int n = start;
    int dones = 0;
    while (!tag_rdy && n < 200) begin
      inv_all_req = (n == inv_at);
      if (n >= wr_from && n < wr_to) begin
        tag_req = 1'b1; tag_gwen = 1'b0; tag_idx = 6'd7; tag_way = '1; tag_wen = '0; tag_din = '1;
      end else begin
        tag_req = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (inv_all_done) dones++;
    end
    inv_all_req = 1'b0; tag_req = 1'b0;
    check({name, "_len"}, n, 64);
    check({name, "_done_at_rdy"}, inv_all_done, 1);
    check({name, "_done_count"}, dones, 1);
    @(posedge clk); #1;
    check({name, "_done_low"}, inv_all_done, 0);
    model_clear();
  endtask

  typedef struct {
    logic                rd;
    logic [INDEX_W-1:0]  idx;
    logic [WAYS-1:0]     way;
    logic [DW-1:0]       wen;
    logic [DW-1:0]       din;
    logic [DW-1:0]       exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [DW-1:0] d9;
    logic [127:0] r128;
    logic prev_rd;
    logic [DW-1:0] prev_exp;
    int e0, e1;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", tag_rdy, 0);
    check("rst_dout", tag_dout, 0);
    check("rst_vld", tag_dout_vld, 0);
    check("rst_par", tag_par_err, 0);
    check("rst_done", inv_all_done, 0);
    rst = 1'b0;
    wait_sweep("init", 0, -1, -1, -1);

    for (int i = 0; i < DEPTH; i++) do_read($sformatf("zero%0d", i), i[INDEX_W-1:0], 4'hF);

    // Directed table.
    d9 = ent(0, 29'h1000_0011) | ent(1, 29'h1222_2222) | ent(2, 29'h1333_3333) | ent(3, 29'h0444_4444);
    vecs[0] = '{1'b0, 6'd5, 4'b0100, ~ent(2, '1), ent(2, 29'h1ABCDE12), '0};
    vecs[1] = '{1'b1, 6'd5, 4'b1111, '1, '0, ent(2, 29'h1ABCDE12)};
    vecs[2] = '{1'b0, 6'd5, 4'b0100, ~ent(2, 29'h1000_0000), '0, '0};
    vecs[3] = '{1'b1, 6'd5, 4'b1111, '1, '0, ent(2, 29'h0ABCDE12)};
    vecs[4] = '{1'b0, 6'd9, 4'b1111, '0, d9, '0};
    vecs[5] = '{1'b1, 6'd9, 4'b0001, '1, '0, ent(0, 29'h1000_0011) | ent(1, 29'h1222_2222)};
    vecs[6] = '{1'b1, 6'd9, 4'b1000, '1, '0, ent(2, 29'h1333_3333) | ent(3, 29'h0444_4444)};
    vecs[7] = '{1'b1, 6'd9, 4'b0000, '1, '0, '0};

    for (int i = 0; i < 8; i++) begin
      e0 = b_edges[0]; e1 = b_edges[1];
      issue(vecs[i].rd, vecs[i].idx, vecs[i].way, vecs[i].wen, vecs[i].din, 1'b0);
      if (vecs[i].rd) begin
        @(posedge clk); #1;
        check($sformatf("vec%0d_vld", i), tag_dout_vld, 1);
        check($sformatf("vec%0d_dout", i), tag_dout, vecs[i].exp);
        ref_dout = vecs[i].exp;
      end else begin
        model_write(vecs[i].idx, vecs[i].way, vecs[i].wen, vecs[i].din);
      end
      check($sformatf("vec%0d_bank0_edges", i), b_edges[0] - e0, bank_hit(vecs[i].way, 0));
      check($sformatf("vec%0d_bank1_edges", i), b_edges[1] - e1, bank_hit(vecs[i].way, 1));
      @(posedge clk); #1;
      check($sformatf("vec%0d_vld_low", i), tag_dout_vld, 0);
      check($sformatf("vec%0d_hold", i), tag_dout, ref_dout);
    end

    // Randomized back-to-back traffic against the reference model.
    prev_rd = 1'b0;
    prev_exp = ref_dout;
    for (int k = 0; k < 400; k++) begin
      int op;
      logic this_rd;
      logic [DW-1:0] this_exp;
      op = $urandom_range(0, 4);
      icg_en = 1'($urandom_range(0, 1));
      this_rd = 1'b0;
      this_exp = '0;
      tag_req = (op != 0);
      tag_gwen = (op >= 3);
      tag_idx = 6'($urandom_range(0, 7));
      tag_way = 4'($urandom_range(0, 15));
      r128 = {$urandom, $urandom, $urandom, $urandom};
      tag_din = r128[DW-1:0];
`ifdef AQ_DCACHE_TAG_PARITY_EN
      for (int w = 0; w < WAYS; w++) begin
        tag_wen[w*EW +: TAG_W] = {TAG_W{1'($urandom_range(0, 1))}};
        tag_wen[w*EW + TAG_W] = 1'($urandom_range(0, 1));
      end
`else
      r128 = {$urandom, $urandom, $urandom, $urandom};
      tag_wen = r128[DW-1:0];
`endif
      if (tag_req && tag_gwen) begin
        this_rd = 1'b1;
        this_exp = model_read(tag_idx, tag_way);
      end else if (tag_req) begin
        model_write(tag_idx, tag_way, tag_wen, tag_din);
      end
      @(posedge clk); #1;
      if (prev_rd) ref_dout = prev_exp;
      check($sformatf("rnd%0d_vld", k), tag_dout_vld, prev_rd);
      check($sformatf("rnd%0d_dout", k), tag_dout, ref_dout);
      check($sformatf("rnd%0d_par", k), tag_par_err, 0);
      prev_rd = this_rd;
      prev_exp = this_exp;
    end
    tag_req = 1'b0;
    icg_en = 1'b0;
    @(posedge clk); #1;
    if (prev_rd) ref_dout = prev_exp;
    check("rnd_drain_vld", tag_dout_vld, prev_rd);
    check("rnd_drain_dout", tag_dout, ref_dout);

    // Invalidate-all with a valid entry, a dropped write and a second request mid-sweep.
    do_write(6'd5, 4'b0100, '0, ent(2, 29'h1ABCDE12));
    do_read("pre_inv", 6'd5, 4'hF);
    issue(1'b0, 6'd0, 4'h0, '1, '0, 1'b1);
    check("inv_rdy_drop", tag_rdy, 0);
    wait_sweep("inv", 0, 30, 2, 10);
    check("inv_dout_hold", tag_dout, ref_dout);
    do_read("post_inv5", 6'd5, 4'hF);
    check("post_inv5_zero", tag_dout, 0);
    do_read("post_inv7", 6'd7, 4'hF);
    check("post_inv7_zero", tag_dout, 0);

    // Read accepted together with inv_all_req completes before the sweep.
    do_write(6'd3, 4'hF, '0, d9);
    ref_dout = model_read(6'd3, 4'hF);
    issue(1'b1, 6'd3, 4'hF, '1, '0, 1'b1);
    check("combo_rdy_drop", tag_rdy, 0);
    @(posedge clk); #1;
    check("combo_vld", tag_dout_vld, 1);
    check("combo_dout", tag_dout, ref_dout);
    wait_sweep("combo", 1, -1, -1, -1);
    check("combo_dout_hold", tag_dout, ref_dout);
    do_read("post_combo", 6'd3, 4'hF);

    // Reset in the middle of a sweep restarts a full sweep.
    issue(1'b0, 6'd0, 4'h0, '1, '0, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_rdy", tag_rdy, 0);
    check("midrst_dout", tag_dout, 0);
    check("midrst_done", inv_all_done, 0);
    rst = 1'b0;
    ref_dout = '0;
    wait_sweep("midrst", 0, -1, -1, -1);
    do_read("post_midrst", 6'd3, 4'hF);

`ifdef AQ_DCACHE_TAG_PARITY_EN
    do_write(6'd11, 4'b0010, ~ent(1, '1), ent(1, 29'h1000_0007));
    dut.g_bank[0].tag_mem[11][EW] = ~dut.g_bank[0].tag_mem[11][EW];
    ref_mem[1][11][0] = ~ref_mem[1][11][0];
    do_read("par", 6'd11, 4'hF);
    check("par_err", tag_par_err, 4'b0010);
    do_write(6'd12, 4'b0100, ~ent(2, '1), ent(2, 29'h1000_0003));
    do_read("par_clean", 6'd12, 4'hF);
    check("par_err_clean", tag_par_err, 4'b0000);
`else
    do_read("nopar", 6'd3, 4'hF);
    check("nopar_err", tag_par_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
